// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    ZERO = 2'd3
  } state_e;

  localparam int          DIV_WIDTH = 32;
  localparam logic [31:0] DBZ_QUO   = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {P,Q} left, trial-subtract D, keep or restore.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   p_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH:0]   p_next_o,
  output logic [WIDTH-1:0] q_next_o
);

  logic [WIDTH:0]   p_sh;
  logic [WIDTH+1:0] sum;
  logic             ge;

  // Trial subtract as A + ~B + 1; the carry out of bit WIDTH means P_shifted >= D.
  always_comb begin
    p_sh     = {p_i[WIDTH-1:0], q_i[WIDTH-1]};
    sum      = {1'b0, p_sh} + {1'b0, ~{1'b0, d_i}} + {{(WIDTH+1){1'b0}}, 1'b1};
    ge       = sum[WIDTH+1] | p_i[WIDTH];
    p_next_o = ge ? sum[WIDTH:0] : p_sh;
    q_next_o = {q_i[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/seq_div32.sv
// Iterative 32-bit DIV/DIVU unit: one quotient bit per clock, start/busy/done handshake.
module seq_div32
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH-1:0] rem_o,
  output logic             dbz_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   p_q, p_d, p_nx;
  logic [WIDTH-1:0] q_q, q_d, q_nx;
  logic [WIDTH-1:0] d_q, d_d;
  logic             neg_q_q, neg_q_d, neg_r_q, neg_r_d;
  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
  logic             dbz_q, dbz_d, done_q, done_d, busy_q, busy_d;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  div_step #(.WIDTH(WIDTH)) u_step (
    .p_i      (p_q),
    .q_i      (q_q),
    .d_i      (d_q),
    .p_next_o (p_nx),
    .q_next_o (q_nx)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    q_d     = q_q;
    d_d     = d_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          d_d     = cond_neg(divisor_i, signed_i & divisor_i[WIDTH-1]);
          q_d     = cond_neg(dividend_i, signed_i & dividend_i[WIDTH-1]);
          neg_q_d = signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
          neg_r_d = signed_i & dividend_i[WIDTH-1];
          p_d     = '0;
          cnt_d   = '0;
          if (divisor_i == '0) begin
            state_d = ZERO;
            quo_d   = WIDTH'(DBZ_QUO);
            rem_d   = dividend_i;
            dbz_d   = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        p_d   = p_nx;
        q_d   = q_nx;
        cnt_d = cnt_q + CNT_W'(1);
        // Results are registered straight from the last step so done_o lands in cycle WIDTH+1.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIX;
          quo_d   = cond_neg(q_nx, neg_q_q);
          rem_d   = cond_neg(p_nx[WIDTH-1:0], neg_r_q);
          dbz_d   = 1'b0;
          done_d  = 1'b1;
        end
      end
      FIX:     state_d = IDLE;
      ZERO:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CALC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Datapath operands carry no reset; they are always loaded on acceptance.
  always_ff @(posedge clk) begin
    p_q     <= p_d;
    q_q     <= q_d;
    d_q     <= d_d;
    neg_q_q <= neg_q_d;
    neg_r_q <= neg_r_d;
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign quo_o  = quo_q;
  assign rem_o  = rem_q;
  assign dbz_o  = dbz_q;

endmodule

// File: tb/tb_seq_div32.sv
// Self-checking bench for seq_div32: directed vectors, handshake corner cases, random scoreboard.
module tb_seq_div32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] quo_o;
  logic [31:0] rem_o;
  logic        dbz_o;

  int checks = 0;
  int errors = 0;

  seq_div32 dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .signed_i   (signed_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .quo_o      (quo_o),
    .rem_o      (rem_o),
    .dbz_o      (dbz_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    bit          dbz;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain language-level / and %, truncating toward zero.
  task automatic ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output bit z);
    int sa, sb;
    z = 1'b0;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else if (sgn) begin
      sa = int'(a);
      sb = int'(b);
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = 32'(sa / sb);
        r = 32'(sa % sb);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  // Called right after a posedge (cycle 0); returns cycles to done and busy-high count.
  task automatic run_op(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cnt);
    start_i    = 1'b1;
    signed_i   = sgn;
    dividend_i = a;
    divisor_i  = b;
    lat        = 0;
    busy_cnt   = 0;
    do begin
      @(posedge clk);
      #1;
      start_i = 1'b0;
      lat++;
      if (busy_o) busy_cnt++;
    end while (!done_o && lat < 40);
    if (!done_o) chk("done_timeout", 32'(lat), 32'd0);
  endtask

  initial begin
    int          lat, bcnt, c, first_done, second_done, ndone;
    logic [31:0] eq, er, a, b;
    bit          ez, sgn;

    vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 33};
    vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 33};
    vecs[3] = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 1};
    vecs[4] = '{1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0, 33};
    vecs[5] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 33};
    vecs[6] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 33};
    vecs[7] = '{1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1, 1};

    rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; dividend_i = '0; divisor_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_quo",  quo_o, 32'd0);
    chk("rst_rem",  rem_o, 32'd0);
    chk("rst_dbz",  32'(dbz_o), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, lat, bcnt);
      chk("vec_lat",  32'(lat), 32'(vecs[i].lat));
      chk("vec_busy", 32'(bcnt), (vecs[i].lat == 1) ? 32'd0 : 32'd32);
      chk("vec_quo",  quo_o, vecs[i].q);
      chk("vec_rem",  rem_o, vecs[i].r);
      chk("vec_dbz",  32'(dbz_o), 32'(vecs[i].dbz));
      @(posedge clk); #1;
      chk("vec_done_pulse", 32'(done_o), 32'd0);
      chk("vec_quo_hold",   quo_o, vecs[i].q);
    end

    // Start while busy is ignored.
    start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd100; divisor_i = 32'd7;
    ndone = 0; lat = 0;
    for (c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      if (c == 10) begin
        start_i = 1'b1; dividend_i = 32'd50; divisor_i = 32'd5;
      end
      if (c == 11) start_i = 1'b0;
      if (done_o) begin
        ndone++;
        if (lat == 0) lat = c;
      end
    end
    chk("busy_ign_lat",   32'(lat), 32'd33);
    chk("busy_ign_ndone", 32'(ndone), 32'd1);
    chk("busy_ign_quo",   quo_o, 32'd14);
    chk("busy_ign_rem",   rem_o, 32'd2);

    // start_i held through the done cycle: second op accepted the cycle after done.
    start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd100; divisor_i = 32'd7;
    first_done = -1; second_done = -1;
    for (c = 1; c <= 80; c++) begin
      @(posedge clk); #1;
      if (first_done > 0 && c == first_done + 2) start_i = 1'b0;
      if (done_o) begin
        if (first_done < 0) begin
          first_done = c;
          chk("held_quo1", quo_o, 32'd14);
          dividend_i = 32'd9; divisor_i = 32'd4;
        end else begin
          second_done = c;
          break;
        end
      end
    end
    start_i = 1'b0;
    chk("held_done1", 32'(first_done), 32'd33);
    chk("held_done2", 32'(second_done), 32'd67);
    chk("held_quo2",  quo_o, 32'd2);
    chk("held_rem2",  rem_o, 32'd1);
    @(posedge clk); #1;

    // Reset mid-operation aborts without done.
    start_i = 1'b1; signed_i = 1'b1; dividend_i = 32'd1000; divisor_i = 32'd3;
    for (c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_done", 32'(done_o), 32'd0);
    chk("abort_quo",  quo_o, 32'd0);
    chk("abort_rem",  rem_o, 32'd0);
    chk("abort_dbz",  32'(dbz_o), 32'd0);
    ndone = 0;
    for (c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done_o || busy_o) ndone++;
    end
    chk("abort_quiet", 32'(ndone), 32'd0);
    run_op(1'b0, 32'd9, 32'd4, lat, bcnt);
    chk("after_abort_quo", quo_o, 32'd2);
    chk("after_abort_rem", rem_o, 32'd1);
    @(posedge clk); #1;

    // Random scoreboard.
    for (int n = 0; n < 2000; n++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom();
      b   = $urandom();
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 20));
        2: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        3: begin a = 32'h8000_0000; b = $urandom_range(0, 1) ? 32'hFFFF_FFFF : b; end
        4: a = 32'($urandom_range(0, 100));
        default: ;
      endcase
      ref_div(sgn, a, b, eq, er, ez);
      run_op(sgn, a, b, lat, bcnt);
      chk("rnd_quo", quo_o, eq);
      chk("rnd_rem", rem_o, er);
      chk("rnd_dbz", 32'(dbz_o), 32'(ez));
      chk("rnd_lat", 32'(lat), ez ? 32'd1 : 32'd33);
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
